// File: rtl/tpu_host_bridge_if.sv
// Purpose: bundles the upstream job stream, downstream result stream and TPU serial port of the host bridge.
// Latency: none, signal bundle only.
// Backpressure: s_* and r_* use valid/ready; the TPU side is gated by tpu_ready, results arrive without backpressure.
//
// Ports (master = bridge side):
//   s_valid/s_data/s_ready      upstream words, matrix A then matrix B, row-major
//   r_valid/r_data/r_last/r_ready  result words to the downstream sink
//   tpu_enable/tpu_valid/tpu_data/tpu_ready  load path into the TPU
//   tpu_err/tpu_done/tpu_data_out            status and result path from the TPU
interface tpu_host_bridge_if;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        r_valid;
    logic [31:0] r_data;
    logic        r_last;
    logic        r_ready;
    logic        tpu_enable;
    logic        tpu_valid;
    logic [31:0] tpu_data;
    logic        tpu_ready;
    logic        tpu_err;
    logic        tpu_done;
    logic [31:0] tpu_data_out;

    modport master (
        input  s_valid, s_data, r_ready, tpu_ready, tpu_err, tpu_done, tpu_data_out,
        output s_ready, r_valid, r_data, r_last, tpu_enable, tpu_valid, tpu_data
    );

    modport slave (
        output s_valid, s_data, r_ready, tpu_ready, tpu_err, tpu_done, tpu_data_out,
        input  s_ready, r_valid, r_data, r_last, tpu_enable, tpu_valid, tpu_data
    );
endinterface

// File: rtl/tpu_host_bridge.sv
// Purpose: host-side TPU initiator; streams one job (A then B) into the TPU, captures N*M results, drains them downstream.
// Latency: load path is combinational pass-through; first r_valid comes N*M+1 cycles after the tpu_done cycle.
// Backpressure: s_ready follows tpu_ready while loading; results are buffered so r_ready may stall the drain indefinitely.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         one-cycle pulse, accepted only when idle
//   busy          high whenever a job is in progress
//   error/err_code  sticky error (1 = TPU error, 2 = timeout), cleared by the next accepted start
//   bus           tpu_host_bridge_if master: upstream, downstream and TPU signals
module tpu_host_bridge #(
    parameter int A       = 4,
    parameter int M       = 4,
    parameter int N       = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              error,
    output logic [1:0]        err_code,
    tpu_host_bridge_if.master bus
);
    localparam int A_WORDS   = A * N;
    localparam int B_WORDS   = A * M;
    localparam int RES_WORDS = N * M;
    localparam int LOAD_MAX  = (A_WORDS > B_WORDS) ? A_WORDS : B_WORDS;
    // Each counter only ever holds 0..max-1, so it is sized for that range.
    localparam int LOAD_W    = (LOAD_MAX  > 1) ? $clog2(LOAD_MAX)  : 1;
    localparam int IDX_W     = (RES_WORDS > 1) ? $clog2(RES_WORDS) : 1;
    localparam int WAIT_W    = (TIMEOUT   > 1) ? $clog2(TIMEOUT)   : 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD_A    = 3'd1;
    localparam logic [2:0] LOAD_B    = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] CAPTURE   = 3'd4;
    localparam logic [2:0] DRAIN     = 3'd5;

    logic [2:0]        state;
    logic [LOAD_W-1:0] loadCnt;
    logic [WAIT_W-1:0] waitCnt;
    logic [IDX_W-1:0]  wrIdx;
    logic [IDX_W-1:0]  rdIdx;
    logic [31:0]       resBuf [RES_WORDS];

    logic inLoad;
    logic xfer;
    logic tpuActive;

    assign inLoad    = (state == LOAD_A) || (state == LOAD_B);
    assign xfer      = inLoad && bus.s_valid && bus.tpu_ready;
    assign tpuActive = inLoad || (state == WAIT_DONE) || (state == CAPTURE);

    assign busy           = (state != IDLE);
    assign bus.tpu_enable = tpuActive;
    assign bus.tpu_valid  = inLoad ? bus.s_valid : 1'b0;
    assign bus.tpu_data   = inLoad ? bus.s_data : 32'd0;
    assign bus.s_ready    = inLoad ? bus.tpu_ready : 1'b0;
    assign bus.r_valid    = (state == DRAIN);
    assign bus.r_data     = (state == DRAIN) ? resBuf[rdIdx] : 32'd0;
    assign bus.r_last     = (state == DRAIN) && (rdIdx == IDX_W'(RES_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            error    <= 1'b0;
            err_code <= 2'd0;
            loadCnt  <= '0;
            waitCnt  <= '0;
            wrIdx    <= '0;
            rdIdx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD_A;
                        error    <= 1'b0;
                        err_code <= 2'd0;
                        loadCnt  <= '0;
                        waitCnt  <= '0;
                        wrIdx    <= '0;
                        rdIdx    <= '0;
                    end
                end
                // tpu_done is meaningless while loading and is deliberately ignored.
                LOAD_A, LOAD_B: begin
                    if (bus.tpu_err) begin
                        state    <= IDLE;
                        error    <= 1'b1;
                        err_code <= 2'd1;
                    end else if (xfer) begin
                        if (state == LOAD_A && loadCnt == LOAD_W'(A_WORDS - 1)) begin
                            state   <= LOAD_B;
                            loadCnt <= '0;
                        end else if (state == LOAD_B && loadCnt == LOAD_W'(B_WORDS - 1)) begin
                            state   <= WAIT_DONE;
                            loadCnt <= '0;
                            waitCnt <= '0;
                        end else begin
                            loadCnt <= loadCnt + 1'b1;
                        end
                    end
                end
                // tpu_err is checked first so it wins over a coincident timeout.
                WAIT_DONE: begin
                    if (bus.tpu_err) begin
                        state    <= IDLE;
                        error    <= 1'b1;
                        err_code <= 2'd1;
                    end else if (bus.tpu_done) begin
                        state   <= CAPTURE;
                        waitCnt <= '0;
                        wrIdx   <= '0;
                    end else if (waitCnt == WAIT_W'(TIMEOUT - 1)) begin
                        state    <= IDLE;
                        error    <= 1'b1;
                        err_code <= 2'd2;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    if (bus.tpu_err) begin
                        state    <= IDLE;
                        error    <= 1'b1;
                        err_code <= 2'd1;
                    end else if (wrIdx == IDX_W'(RES_WORDS - 1)) begin
                        state <= DRAIN;
                        wrIdx <= '0;
                        rdIdx <= '0;
                    end else begin
                        wrIdx <= wrIdx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.r_ready) begin
                        if (rdIdx == IDX_W'(RES_WORDS - 1)) begin
                            state <= IDLE;
                            rdIdx <= '0;
                        end else begin
                            rdIdx <= rdIdx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The TPU cannot be stalled, so every CAPTURE cycle writes a word.
    always_ff @(posedge clk) begin
        if (state == CAPTURE) begin
            resBuf[wrIdx] <= bus.tpu_data_out;
        end
    end
endmodule

// File: tb/tb_tpu_host_bridge.sv
module tb_tpu_host_bridge;
    localparam int NA    = 4;
    localparam int NM    = 4;
    localparam int NN    = 4;
    localparam int TMO   = 8;
    localparam int NLOAD = NA * NN + NA * NM;
    localparam int NRES  = NN * NM;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       error;
    logic [1:0] err_code;

    tpu_host_bridge_if bus();

    tpu_host_bridge #(.A(NA), .M(NM), .N(NN), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .error    (error),
        .err_code (err_code),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        sv;
        logic        tr;
        logic [31:0] d;
        logic        expRdy;
        logic        expVld;
        logic [31:0] expDat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetVals(input string tag);
        bus.s_valid   = 1'b1;
        bus.tpu_ready = 1'b1;
        bus.s_data    = 32'hDEAD_BEEF;
        #1;
        chk({tag, "_busy"},       32'(busy), 0);
        chk({tag, "_error"},      32'(error), 0);
        chk({tag, "_err_code"},   32'(err_code), 0);
        chk({tag, "_s_ready"},    32'(bus.s_ready), 0);
        chk({tag, "_tpu_valid"},  32'(bus.tpu_valid), 0);
        chk({tag, "_tpu_enable"}, 32'(bus.tpu_enable), 0);
        chk({tag, "_tpu_data"},   bus.tpu_data, 0);
        chk({tag, "_r_valid"},    32'(bus.r_valid), 0);
        chk({tag, "_r_last"},     32'(bus.r_last), 0);
        chk({tag, "_r_data"},     bus.r_data, 0);
        bus.s_valid   = 1'b0;
        bus.tpu_ready = 1'b0;
    endtask

    // Start a job and push all A and B words with source and TPU always ready.
    task automatic quickLoad();
        start = 1'b1;
        step();
        start         = 1'b0;
        bus.s_valid   = 1'b1;
        bus.tpu_ready = 1'b1;
        for (int i = 0; i < NLOAD; i++) begin
            bus.s_data = 32'(i);
            step();
        end
        bus.s_valid = 1'b0;
    endtask

    // Full job against the reference: the source offers base+k until it is taken, results are resBase+k.
    task automatic runJob(input bit rnd, input int doneDelay, input int stallWord,
                          input logic [31:0] base, input logic [31:0] resBase);
        logic [31:0] expRes[$];
        logic        sv;
        logic        tr;
        int          n;
        int          cyc;
        int          rd;
        int          stall;

        start = 1'b1; bus.s_valid = 1'b1; bus.tpu_ready = 1'b1; bus.s_data = base;
        #1;
        chk("idle_s_ready", 32'(bus.s_ready), 0);
        step();
        start = 1'b0;

        n = 0;
        cyc = 0;
        while (n < NLOAD && cyc < 1000) begin
            sv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.s_valid   = sv;
            bus.tpu_ready = tr;
            bus.s_data    = base + 32'(n);
            bus.tpu_done  = rnd && ($urandom_range(0, 7) == 0);
            start         = rnd && ($urandom_range(0, 7) == 0);
            #1;
            chk("load_tpu_data",   bus.tpu_data, base + 32'(n));
            chk("load_tpu_valid",  32'(bus.tpu_valid), 32'(sv));
            chk("load_s_ready",    32'(bus.s_ready), 32'(tr));
            chk("load_tpu_enable", 32'(bus.tpu_enable), 1);
            if (sv && tr) n++;
            step();
            cyc++;
        end
        if (n < NLOAD) chk("load_budget", 32'(n), 32'(NLOAD));

        bus.s_valid = 1'b1; bus.tpu_ready = 1'b1; bus.tpu_done = 1'b0; start = 1'b0;
        #1;
        chk("wait_s_ready",   32'(bus.s_ready), 0);
        chk("wait_tpu_valid", 32'(bus.tpu_valid), 0);
        chk("wait_enable",    32'(bus.tpu_enable), 1);
        chk("wait_busy",      32'(busy), 1);
        for (int d = 0; d < doneDelay; d++) begin
            step();
            #1;
            chk("wait_busy_hold", 32'(busy), 1);
        end
        bus.s_valid  = 1'b0;
        bus.tpu_done = 1'b1;
        step();
        bus.tpu_done = 1'b0;

        for (int i = 0; i < NRES; i++) begin
            bus.tpu_data_out = resBase + 32'(i);
            expRes.push_back(resBase + 32'(i));
            #1;
            chk("cap_r_valid", 32'(bus.r_valid), 0);
            chk("cap_enable",  32'(bus.tpu_enable), 1);
            step();
        end

        rd = 0;
        stall = 0;
        cyc = 0;
        while (rd < NRES && cyc < 500) begin
            bus.tpu_data_out = $urandom;
            if (rd == stallWord && stall < 5) begin
                bus.r_ready = 1'b0;
                stall++;
            end else begin
                bus.r_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            #1;
            chk("drain_r_valid", 32'(bus.r_valid), 1);
            chk("drain_r_data",  bus.r_data, expRes[rd]);
            chk("drain_r_last",  32'(bus.r_last), 32'(rd == NRES - 1));
            chk("drain_enable",  32'(bus.tpu_enable), 0);
            if (bus.r_ready) rd++;
            step();
            cyc++;
        end
        if (rd < NRES) chk("drain_budget", 32'(rd), 32'(NRES));
        bus.r_ready = 1'b0;
        #1;
        chk("end_busy",    32'(busy), 0);
        chk("end_r_valid", 32'(bus.r_valid), 0);
        chk("end_error",   32'(error), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = 32'd0; bus.r_ready = 1'b0;
        bus.tpu_ready = 1'b0; bus.tpu_err = 1'b0; bus.tpu_done = 1'b0; bus.tpu_data_out = 32'd0;

        vecs[0] = '{1'b1, 1'b0, 32'hA5A5_0001, 1'b0, 1'b1, 32'hA5A5_0001};
        vecs[1] = '{1'b0, 1'b1, 32'hA5A5_0002, 1'b1, 1'b0, 32'hA5A5_0002};
        vecs[2] = '{1'b0, 1'b0, 32'hA5A5_0003, 1'b0, 1'b0, 32'hA5A5_0003};
        vecs[3] = '{1'b1, 1'b1, 32'hA5A5_0004, 1'b1, 1'b1, 32'hA5A5_0004};
        vecs[4] = '{1'b1, 1'b0, 32'h5A5A_0005, 1'b0, 1'b1, 32'h5A5A_0005};
        vecs[5] = '{1'b1, 1'b1, 32'h5A5A_0006, 1'b1, 1'b1, 32'h5A5A_0006};

        repeat (3) step();
        checkResetVals("reset");
        rst = 1'b0;
        step();

        // Pass-through vectors applied in LOAD_A.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.s_valid = vecs[i].sv; bus.tpu_ready = vecs[i].tr; bus.s_data = vecs[i].d;
            #1;
            chk("vec_s_ready",   32'(bus.s_ready), 32'(vecs[i].expRdy));
            chk("vec_tpu_valid", 32'(bus.tpu_valid), 32'(vecs[i].expVld));
            chk("vec_tpu_data",  bus.tpu_data, vecs[i].expDat);
            chk("vec_busy",      32'(busy), 1);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;

        runJob(1'b0, 0, -1, 32'd1, 32'h100);
        runJob(1'b0, 2, 3, 32'h200, 32'h100);

        // TPU error on the 10th LOAD_A transfer.
        start = 1'b1;
        step();
        start = 1'b0; bus.s_valid = 1'b1; bus.tpu_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.s_data  = 32'(i);
            bus.tpu_err = (i == 9);
            step();
        end
        bus.tpu_err = 1'b0;
        #1;
        chk("err_busy",     32'(busy), 0);
        chk("err_error",    32'(error), 1);
        chk("err_code",     32'(err_code), 1);
        chk("err_enable",   32'(bus.tpu_enable), 0);
        chk("err_s_ready",  32'(bus.s_ready), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        chk("err_clr_error", 32'(error), 0);
        chk("err_clr_code",  32'(err_code), 0);
        chk("err_clr_busy",  32'(busy), 1);
        rst = 1'b1; step(); rst = 1'b0;

        // Timeout: TMO WAIT_DONE cycles without tpu_done.
        quickLoad();
        for (int w = 1; w < TMO; w++) step();
        #1;
        chk("tmo_busy_before",  32'(busy), 1);
        chk("tmo_error_before", 32'(error), 0);
        step();
        #1;
        chk("tmo_busy",   32'(busy), 0);
        chk("tmo_error",  32'(error), 1);
        chk("tmo_code",   32'(err_code), 2);
        chk("tmo_enable", 32'(bus.tpu_enable), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        chk("tmo_clr_code", 32'(err_code), 0);
        rst = 1'b1; step(); rst = 1'b0;

        // TPU error coinciding with the timeout cycle.
        quickLoad();
        for (int w = 1; w < TMO; w++) step();
        bus.tpu_err = 1'b1;
        step();
        bus.tpu_err = 1'b0;
        #1;
        chk("errtmo_code",  32'(err_code), 1);
        chk("errtmo_error", 32'(error), 1);
        chk("errtmo_busy",  32'(busy), 0);

        // Reset in the middle of LOAD_B, then a clean job.
        start = 1'b1;
        step();
        start = 1'b0; bus.s_valid = 1'b1; bus.tpu_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.s_data = 32'(i);
            step();
        end
        rst = 1'b1;
        step();
        checkResetVals("midrst");
        rst = 1'b0;
        step();
        runJob(1'b0, 1, -1, 32'h300, 32'h400);

        for (int k = 0; k < 4; k++) begin
            runJob(1'b1, int'($urandom_range(0, 6)), int'($urandom_range(0, 15)), $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tpu_host_bridge.md
Name: tpu_host_bridge

Overview:
Host-side initiator for the TPU serial port. It streams one job (matrix A, then matrix B) from an upstream valid/ready source into the TPU's enable/valid/ready/data_in interface. It then captures the N*M result words the TPU emits without backpressure into an internal buffer and drains them to a downstream valid/ready sink. It sits between the system interconnect and the TPU top level.

Parameters:
A, 4, shared (inner) dimension; A*N words for matrix A, A*M words for matrix B
M, 4, columns of B / result
N, 4, rows of A / result
TIMEOUT, 1024, max cycles in WAIT_DONE before a timeout error (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a job when idle
busy  output  1  high in every state except IDLE
error  output  1  sticky error flag, cleared on next accepted start
err_code  output  2  0 none, 1 TPU err, 2 timeout
s_valid  input  1  upstream word valid
s_data  input  32  upstream word (A row-major, then B row-major)
s_ready  output  1  upstream word accepted when s_valid&&s_ready
r_valid  output  1  result word valid
r_data  output  32  result word
r_last  output  1  high with final result word (index N*M-1)
r_ready  input  1  downstream accepts result
tpu_enable  output  1  to TPU enable
tpu_valid  output  1  to TPU valid
tpu_data  output  32  to TPU data_in
tpu_ready  input  1  from TPU ready
tpu_err  input  1  from TPU err
tpu_done  input  1  from TPU done (one-cycle pulse)
tpu_data_out  input  32  from TPU data_out

Behaviour:
- Reset (also mid-job): state IDLE; busy, error, s_ready, r_valid, r_last, tpu_enable, tpu_valid = 0; err_code = 0; r_data, tpu_data = 0; all counters 0; buffer contents don't-care.
- FSM states: IDLE, LOAD_A, LOAD_B, WAIT_DONE, CAPTURE, DRAIN.
- IDLE: start -> LOAD_A; clear error/err_code, zero counters. start in any other state is ignored.
- tpu_enable = 1 in LOAD_A, LOAD_B, WAIT_DONE, CAPTURE.
- LOAD_A/LOAD_B: combinational pass-through: tpu_valid = s_valid, tpu_data = s_data, s_ready = tpu_ready. A word transfers when s_valid && tpu_ready. After A*N transfers go to LOAD_B; after A*M further transfers go to WAIT_DONE. The transition happens on the clock edge of the last transfer. Outside load states s_ready = tpu_valid = 0.
- WAIT_DONE: a cycle counter increments each cycle. tpu_done -> CAPTURE, counter cleared. Counter reaching TIMEOUT without done -> IDLE with error = 1, err_code = 2.
- tpu_done during LOAD states is a protocol violation: ignored.
- CAPTURE: the TPU presents result words on tpu_data_out on the N*M consecutive cycles starting the cycle after tpu_done, row-major (n outer, m inner). Capture one word per cycle into buffer[idx], idx 0..N*M-1, with no gaps. After word N*M-1 go to DRAIN.
- DRAIN: r_valid = 1, r_data = buffer[rd_idx], r_last = (rd_idx == N*M-1). rd_idx advances on r_valid && r_ready. The handshake on the last word -> IDLE. r_valid must not drop while waiting for r_ready.
- tpu_err in LOAD_A/LOAD_B/WAIT_DONE/CAPTURE: next state IDLE, error = 1, err_code = 1; tpu_enable drops the following cycle.
- If tpu_err and timeout occur in the same cycle, tpu_err wins (err_code 1).
- Counters are sized $clog2 of their maximum + 1; no wrap within a job.
- Latency: first TPU transfer can occur the cycle after start. First r_valid occurs N*M+1 cycles after the tpu_done cycle.

Test Plan:
- A=M=N=4, tpu_ready held 1, s_valid always 1, data 1..32 -> exactly 16 words enter LOAD_A and 16 enter LOAD_B; tpu_data matches s_data each cycle; state reaches WAIT_DONE after cycle 32.
- Model TPU toggles tpu_ready 1/0 and s_valid randomly -> still exactly 32 transfers; no word duplicated or dropped.
- tpu_done, then tpu_data_out = 0x100..0x10F on the next 16 cycles, r_ready = 1 -> r_data 0x100..0x10F in order; r_last only with 0x10F; busy falls the next cycle.
- During DRAIN, r_ready low for 5 cycles on word 3 -> r_valid stays 1, r_data stays 0x103, no capture-buffer corruption.
- tpu_err pulsed on the 10th LOAD_A transfer -> IDLE next cycle; error = 1, err_code = 1; next start clears error.
- TIMEOUT = 8 and no tpu_done -> after 8 WAIT_DONE cycles error = 1, err_code = 2, busy = 0; rst asserted mid-LOAD_B -> all outputs return to reset values the next cycle.
